// File: rtl/lock_sequencer.sv
// Lock sequencer for the error-signal stage between the divider and the DAC.
// Steps IDLE -> SETTLE -> (CALIB) -> RUN, with overload HOLD/relock, and drives trigger_enable/setpoint_out.
module lock_sequencer #(
    parameter int DATA_WIDTH   = 26,
    parameter int LOG2_AVG     = 4,
    parameter int SETTLE_TRIGS = 16,
    parameter int HOLD_TRIGS   = 64,
    parameter int OVL_THRESH   = 163,
    parameter int OVL_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXIS_in_tdata,
    input  logic        S_AXIS_in_tvalid,
    input  logic        fg_trigger,
    input  logic [31:0] gpio_ctrl,
    input  logic [31:0] gpio_setpoint,
    output logic        trigger_enable,
    output logic [31:0] setpoint_out,
    output logic [2:0]  state,
    output logic        locked,
    output logic [15:0] overload_count
);

    localparam int AW = DATA_WIDTH + LOG2_AVG;
    localparam int EW = 16;
    localparam logic [EW-1:0] SETTLE_LAST = EW'(SETTLE_TRIGS - 1);
    localparam logic [EW-1:0] HOLD_LAST   = EW'(HOLD_TRIGS - 1);
    localparam logic [EW-1:0] CAL_LAST    = EW'((1 << LOG2_AVG) - 1);
    localparam logic [7:0]    OVL_LAST    = 8'(OVL_LIMIT - 1);
    localparam logic signed [DATA_WIDTH:0] THR_P = (DATA_WIDTH+1)'(OVL_THRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CALIB  = 3'd2,
        S_RUN    = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    function automatic logic signed [DATA_WIDTH-1:0] avg_floor(input logic signed [AW-1:0] a);
        return DATA_WIDTH'(a >>> LOG2_AVG);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sext32(input logic signed [DATA_WIDTH-1:0] v);
        return 32'(v);
    endfunction

    logic enable, auto_sp, force_hold;
    assign enable     = gpio_ctrl[0];
    assign auto_sp    = gpio_ctrl[1];
    assign force_hold = gpio_ctrl[2];

    logic unused_bits;
    assign unused_bits = ^{gpio_ctrl[31:3], gpio_setpoint[31:DATA_WIDTH], S_AXIS_in_tdata[31:DATA_WIDTH]};

    // Stage p0: trigger synchroniser and falling-edge detect (raw edge -> trig_evt in 3 clk)
    logic trig_s1, trig_s2, trig_s3, trig_evt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            trig_s1  <= 1'b0;
            trig_s2  <= 1'b0;
            trig_s3  <= 1'b0;
            trig_evt <= 1'b0;
        end else begin
            trig_s1  <= fg_trigger;
            trig_s2  <= trig_s1;
            trig_s3  <= trig_s2;
            trig_evt <= trig_s3 & ~trig_s2;
        end
    end

    // Stage p0: sample latch; a sample arriving with trig_evt bypasses the latch
    logic signed [DATA_WIDTH-1:0] smp_p0, smp_cur, sp_act;
    logic svalid, evt_smp;
    always_ff @(posedge clk) begin
        if (S_AXIS_in_tvalid)
            smp_p0 <= $signed(S_AXIS_in_tdata[DATA_WIDTH-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            svalid <= 1'b0;
        else if (trig_evt)
            svalid <= 1'b0;
        else if (S_AXIS_in_tvalid)
            svalid <= 1'b1;
    end

    assign smp_cur = S_AXIS_in_tvalid ? $signed(S_AXIS_in_tdata[DATA_WIDTH-1:0]) : smp_p0;
    assign evt_smp = trig_evt & (S_AXIS_in_tvalid | svalid);
    assign sp_act  = $signed(setpoint_out[DATA_WIDTH-1:0]);

    logic signed [DATA_WIDTH:0] diff;
    logic ovl_hit;
    assign diff    = (DATA_WIDTH+1)'(smp_cur) - (DATA_WIDTH+1)'(sp_act);
    assign ovl_hit = (diff > THR_P) || (diff < -THR_P);

    logic signed [AW-1:0] acc, acc_nxt;
    assign acc_nxt = acc + AW'(smp_cur);

    // Stage p1: sequencer state and registered outputs
    state_t st;
    logic [EW-1:0] ev_cnt;
    logic [7:0] ovl_cnt;
    logic signed [DATA_WIDTH-1:0] cal_sp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st             <= S_IDLE;
            ev_cnt         <= '0;
            ovl_cnt        <= '0;
            acc            <= '0;
            cal_sp         <= '0;
            trigger_enable <= 1'b0;
            setpoint_out   <= '0;
            locked         <= 1'b0;
            overload_count <= '0;
        end else begin
            trigger_enable <= 1'b0;
            setpoint_out   <= auto_sp ? sext32(cal_sp)
                                      : sext32($signed(gpio_setpoint[DATA_WIDTH-1:0]));
            if (!enable) begin
                st      <= S_IDLE;
                ev_cnt  <= '0;
                ovl_cnt <= '0;
                locked  <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: begin
                        st      <= S_SETTLE;
                        ev_cnt  <= '0;
                        ovl_cnt <= '0;
                    end
                    S_SETTLE: begin
                        if (trig_evt) begin
                            if (ev_cnt == SETTLE_LAST) begin
                                ev_cnt  <= '0;
                                ovl_cnt <= '0;
                                acc     <= '0;
                                if (auto_sp) begin
                                    st <= S_CALIB;
                                end else begin
                                    st     <= S_RUN;
                                    locked <= 1'b1;
                                end
                            end else begin
                                ev_cnt <= ev_cnt + 1'b1;
                            end
                        end
                    end
                    S_CALIB: begin
                        if (evt_smp) begin
                            acc <= acc_nxt;
                            if (ev_cnt == CAL_LAST) begin
                                cal_sp <= avg_floor(acc_nxt);
                                if (auto_sp)
                                    setpoint_out <= sext32(avg_floor(acc_nxt));
                                st      <= S_RUN;
                                locked  <= 1'b1;
                                ev_cnt  <= '0;
                                ovl_cnt <= '0;
                            end else begin
                                ev_cnt <= ev_cnt + 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (force_hold) begin
                            st      <= S_HOLD;
                            locked  <= 1'b0;
                            ev_cnt  <= '0;
                            ovl_cnt <= '0;
                        end else if (evt_smp) begin
                            // the sample that completes the overload run gets no pulse
                            if (ovl_hit && ovl_cnt == OVL_LAST) begin
                                st             <= S_HOLD;
                                locked         <= 1'b0;
                                overload_count <= sat_inc16(overload_count);
                                ev_cnt         <= '0;
                                ovl_cnt        <= '0;
                            end else begin
                                trigger_enable <= 1'b1;
                                ovl_cnt        <= ovl_hit ? ovl_cnt + 1'b1 : '0;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (trig_evt) begin
                            if (ev_cnt == HOLD_LAST) begin
                                st      <= S_SETTLE;
                                ev_cnt  <= '0;
                                ovl_cnt <= '0;
                            end else begin
                                ev_cnt <= ev_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        st     <= S_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: transaction-level model of trigger events, randomized samples.
module tb_lock_sequencer;

    localparam int SETTLE_TRIGS = 16;
    localparam int HOLD_TRIGS   = 64;
    localparam int N_AVG        = 16;
    localparam int OVL_THRESH   = 163;
    localparam int OVL_LIMIT    = 4;
    localparam int ST_IDLE = 0, ST_SETTLE = 1, ST_CALIB = 2, ST_RUN = 3, ST_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        fg = 1'b1;
    logic [31:0] gpio_ctrl = '0;
    logic [31:0] gpio_setpoint = '0;
    logic        trigger_enable;
    logic [31:0] setpoint_out;
    logic [2:0]  state;
    logic        locked;
    logic [15:0] overload_count;

    lock_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .S_AXIS_in_tdata  (tdata),
        .S_AXIS_in_tvalid (tvalid),
        .fg_trigger       (fg),
        .gpio_ctrl        (gpio_ctrl),
        .gpio_setpoint    (gpio_setpoint),
        .trigger_enable   (trigger_enable),
        .setpoint_out     (setpoint_out),
        .state            (state),
        .locked           (locked),
        .overload_count   (overload_count)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model, advanced once per trigger event
    int     m_state = ST_IDLE;
    int     m_cnt = 0;
    int     m_ovl = 0;
    int     m_man = 0;
    int     m_cal = 0;
    int     m_ovc = 0;
    bit     m_auto = 1'b0;
    longint m_acc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int active_sp();
        return m_auto ? m_cal : m_man;
    endfunction

    function automatic int floor_avg(input longint a);
        longint q;
        q = a / N_AVG;
        if ((a % N_AVG != 0) && (a < 0))
            q = q - 1;
        return int'(q);
    endfunction

    function automatic bit model_evt(input bit hs, input int s);
        bit p;
        int d;
        p = 1'b0;
        case (m_state)
            ST_SETTLE: begin
                m_cnt++;
                if (m_cnt == SETTLE_TRIGS) begin
                    m_state = m_auto ? ST_CALIB : ST_RUN;
                    m_cnt = 0;
                    m_ovl = 0;
                    m_acc = 0;
                end
            end
            ST_CALIB: if (hs) begin
                m_acc += s;
                m_cnt++;
                if (m_cnt == N_AVG) begin
                    m_cal = floor_avg(m_acc);
                    m_state = ST_RUN;
                    m_cnt = 0;
                end
            end
            ST_RUN: if (hs) begin
                d = s - active_sp();
                if (d > OVL_THRESH || d < -OVL_THRESH) begin
                    m_ovl++;
                    if (m_ovl == OVL_LIMIT) begin
                        m_state = ST_HOLD;
                        m_ovl = 0;
                        m_cnt = 0;
                        if (m_ovc < 65535) m_ovc++;
                    end else begin
                        p = 1'b1;
                    end
                end else begin
                    m_ovl = 0;
                    p = 1'b1;
                end
            end
            ST_HOLD: begin
                m_cnt++;
                if (m_cnt == HOLD_TRIGS) begin
                    m_state = ST_SETTLE;
                    m_cnt = 0;
                end
            end
            default: ;
        endcase
        return p;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".state"}, 32'(state), 32'(m_state));
        check_val({tag, ".sp"}, setpoint_out, 32'(active_sp()));
        check_val({tag, ".locked"}, 32'(locked), 32'(m_state == ST_RUN));
        check_val({tag, ".ovc"}, 32'(overload_count), 32'(m_ovc));
    endtask

    // One trigger event: optional sample (before or coincident with trig_evt), then raw falling edge
    task automatic do_evt(input bit hs, input bit coin, input int s, input string tag);
        logic [7:0] win;
        bit ep;
        if (hs && !coin) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata = 32'(s);
            @(negedge clk);
            tvalid = 1'b0;
        end
        @(negedge clk);
        fg = 1'b0;
        win = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            win[i-1] = trigger_enable;
            if (i == 3 && hs && coin) begin
                tvalid = 1'b1;
                tdata = 32'(s);
            end
            if (i == 4) tvalid = 1'b0;
        end
        ep = model_evt(hs, s);
        check_val({tag, ".pulse"}, 32'(win), ep ? 32'h8 : 32'h0);
        check_outputs(tag);
        fg = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_evts(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            bit hs;
            bit coin;
            int s;
            hs = ($urandom_range(0, 3) != 0);
            coin = ($urandom_range(0, 3) == 0);
            s = active_sp() + int'($urandom_range(0, 600)) - 300;
            do_evt(hs, coin, s, tag);
        end
    endtask

    task automatic set_ctrl(input logic [31:0] c);
        @(negedge clk);
        gpio_ctrl = c;
        @(negedge clk);
        m_auto = c[1];
        if (!c[0]) begin
            m_state = ST_IDLE; m_cnt = 0; m_ovl = 0;
        end else if (m_state == ST_IDLE) begin
            m_state = ST_SETTLE; m_cnt = 0; m_ovl = 0;
        end else if (c[2] && m_state == ST_RUN) begin
            m_state = ST_HOLD; m_cnt = 0; m_ovl = 0;
        end
        check_outputs("ctrl");
    endtask

    task automatic set_manual(input int v);
        @(negedge clk);
        gpio_setpoint = 32'(v);
        m_man = v;
        @(negedge clk);
        check_val("manual.sp", setpoint_out, 32'(active_sp()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".state"}, 32'(state), 32'd0);
        check_val({tag, ".te"}, 32'(trigger_enable), 32'd0);
        check_val({tag, ".sp"}, setpoint_out, 32'd0);
        check_val({tag, ".locked"}, 32'(locked), 32'd0);
        check_val({tag, ".ovc"}, 32'(overload_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovl_seq[8];
        ovl_seq = '{163, 164, 164, 0, 164, 164, 164, 164};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Manual path
        set_manual(32'h100);
        set_ctrl(32'h1);
        for (int k = 0; k < SETTLE_TRIGS; k++)
            do_evt(1'b1, 1'b0, int'($urandom_range(0, 1000)), "settle");
        check_val("manual.run", 32'(state), 32'd3);
        do_evt(1'b1, 1'b0, 32'h100, "first_pulse");

        // Overload run against setpoint 0
        set_manual(0);
        foreach (ovl_seq[k])
            do_evt(1'b1, 1'b0, ovl_seq[k], "ovl");
        check_val("ovl.hold", 32'(state), 32'd4);
        check_val("ovl.count", 32'(overload_count), 32'd1);

        // Relock
        run_evts(HOLD_TRIGS, "hold");
        check_val("relock.settle", 32'(state), 32'd1);
        run_evts(SETTLE_TRIGS, "relock");
        check_val("relock.run", 32'(state), 32'd3);

        // Skipped and coincident
        do_evt(1'b0, 1'b0, 0, "skip");
        do_evt(1'b1, 1'b1, 37, "coincident");

        run_evts(120, "random");

        // Calibration: 1000/1001 alternating
        set_ctrl(32'h0);
        set_ctrl(32'h3);
        run_evts(SETTLE_TRIGS, "cal_settle");
        check_val("cal.state", 32'(state), 32'd2);
        for (int k = 0; k < N_AVG; k++)
            do_evt(1'b1, (k % 5) == 2, 1000 + (k % 2), "cal_a");
        check_val("cal_a.sp", setpoint_out, 32'd1000);
        check_val("cal_a.run", 32'(state), 32'd3);

        // Calibration: all -3
        set_ctrl(32'h0);
        set_ctrl(32'h3);
        run_evts(SETTLE_TRIGS, "cal_settle");
        for (int k = 0; k < N_AVG; k++)
            do_evt(1'b1, 1'b0, -3, "cal_b");
        check_val("cal_b.sp", setpoint_out, 32'hFFFF_FFFD);

        // Calibration: random signed samples, with skipped events mixed in
        set_ctrl(32'h0);
        set_ctrl(32'h3);
        run_evts(SETTLE_TRIGS, "cal_settle");
        for (int k = 0; k < 24 && m_state == ST_CALIB; k++)
            do_evt($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 10000)) - 5000, "cal_r");
        run_evts(20, "cal_r_run");

        // Disable in the middle of CALIB
        set_ctrl(32'h0);
        set_ctrl(32'h3);
        run_evts(SETTLE_TRIGS, "cal_settle");
        for (int k = 0; k < 5; k++)
            do_evt(1'b1, 1'b0, 500, "cal_part");
        set_ctrl(32'h0);
        check_val("disable.idle", 32'(state), 32'd0);

        // force_hold from RUN
        set_ctrl(32'h1);
        run_evts(SETTLE_TRIGS, "fh_settle");
        set_ctrl(32'h5);
        check_val("force_hold.state", 32'(state), 32'd4);
        do_evt(1'b1, 1'b0, active_sp(), "force_hold_evt");

        // Reset while in RUN
        set_ctrl(32'h0);
        set_ctrl(32'h1);
        run_evts(SETTLE_TRIGS, "rst_settle");
        check_val("rst.pre_run", 32'(state), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        gpio_ctrl = '0;
        rst = 1'b1;
        m_state = ST_IDLE; m_cnt = 0; m_ovl = 0; m_ovc = 0; m_cal = 0; m_auto = 1'b0;
        @(negedge clk);
        check_outputs("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
